// File: rtl/pll_lock_sequencer.sv
// PLL start-up/recovery sequencer: holds PLL in reset, qualifies lock,
// retries failed attempts and releases the downstream system reset.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned CNT_W         = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       pll_ready,
  output logic       pll_fail,
  output logic [2:0] state_o,
  output logic [1:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_WAIT   = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [1:0]       RTY_MAX  = 2'(MAX_RETRIES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             sync1_q, sync2_q;
  logic             pll_rst_q, sys_rst_n_q, ready_q, fail_q;
  logic             lk, fail_att;

  assign lk = sync2_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    retry_d  = retry_q;
    loss_d   = loss_q;
    fail_att = 1'b0;
    if (relock_req) begin
      state_d = S_RESET;
      retry_d = 2'd0;
    end else begin
      unique case (state_q)
        S_RESET:  if (cnt_q == RST_LAST) state_d = S_WAIT;
        S_WAIT: begin
          if (lk) state_d = S_SETTLE;
          else if (cnt_q == TO_LAST) fail_att = 1'b1;
        end
        S_SETTLE: begin
          if (!lk) fail_att = 1'b1;
          else if (cnt_q == STB_LAST) state_d = S_RUN;
        end
        S_RUN: begin
          if (!lk) begin
            state_d = S_RESET;
            retry_d = 2'd0;
            if (loss_q != 8'hff) loss_d = loss_q + 8'd1;
          end
        end
        S_FAIL:   state_d = S_FAIL;
        default:  state_d = S_RESET;
      endcase
      if (fail_att) begin
        if (retry_q < RTY_MAX) begin
          retry_d = retry_q + 2'd1;
          state_d = S_RESET;
        end else begin
          state_d = S_FAIL;
        end
      end
    end
    // relock restarts the RESET count even when already in RESET
    if (relock_req || state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= S_RESET;
      cnt_q       <= '0;
      retry_q     <= 2'd0;
      loss_q      <= 8'd0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      sync1_q     <= pll_locked;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_rst_q   <= (state_d == S_RESET) || (state_d == S_FAIL);
      sys_rst_n_q <= (state_d == S_RUN);
      ready_q     <= (state_d == S_RUN);
      fail_q      <= (state_d == S_FAIL);
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst_n     = sys_rst_n_q;
  assign pll_ready     = ready_q;
  assign pll_fail      = fail_q;
  assign state_o       = state_q;
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;

endmodule
